// File: rtl/fetch_stage.sv
// In-order instruction fetch: issues sequential PCs to instruction memory and buffers responses in a DEPTH-entry queue.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects are ignored and reported on misalign_err.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instruction,
    output logic [31:0] outPC,
    output logic        fetch_valid
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_q_data [DEPTH];
    logic [31:0]   r_q_addr [DEPTH];

    logic          w_redirect;
    logic [31:0]   w_target;
    logic          w_room;
    logic          w_req_fire;
    logic          w_resp_any;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic w_misalign;
    logic r_misalign;

    assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_redirect = redirect_valid && !w_misalign;
    assign w_target   = redirect_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_misalign <= 1'b0;
        else       r_misalign <= w_misalign;
    end

    assign misalign_err = r_misalign;
`else
    assign w_redirect = redirect_valid;
    assign w_target   = redirect_pc & 32'hFFFF_FFFC;
`endif

    // Issue only while every queue slot still has room for its response.
    assign w_room         = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_W;
    assign imem_req_valid = !reset && w_room && !w_redirect;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_resp_any = imem_resp_valid && (r_outstanding != '0);
    assign w_push     = !reset && w_resp_any && !w_redirect && (r_drop == '0);
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && !stall && !w_redirect;

    assign fetch_valid = !w_empty;
    assign instruction = w_empty ? 32'h0 : r_q_data[r_head];
    assign outPC       = w_empty ? 32'h0 : r_q_addr[r_head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            if (w_req_fire && !w_resp_any)
                r_outstanding <= r_outstanding + CW'(1);
            else if (!w_req_fire && w_resp_any)
                r_outstanding <= r_outstanding - CW'(1);

            if (w_redirect) begin
                // Everything already in flight belongs to the old path; a response landing now is part of it.
                r_pc      <= w_target;
                r_resp_pc <= w_target;
                r_drop    <= w_resp_any ? (r_outstanding - CW'(1)) : r_outstanding;
                r_count   <= '0;
                r_head    <= '0;
                r_tail    <= '0;
            end else begin
                if (w_req_fire)
                    r_pc <= r_pc + 32'd4;
                if (w_resp_any) begin
                    if (r_drop != '0) r_drop <= r_drop - CW'(1);
                    else              r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_push) r_tail <= r_tail + PW'(1);
                if (w_pop)  r_head <= r_head + PW'(1);
                if (w_push && !w_pop)
                    r_count <= r_count + CW'(1);
                else if (!w_push && w_pop)
                    r_count <= r_count - CW'(1);
            end
        end
    end

    // Queue storage needs no reset: r_count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_tail] <= imem_resp_data;
            r_q_addr[r_tail] <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table, directed corner sequences and a random phase,
// all checked against an in-order scoreboard of requested addresses.
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instruction;
    logic [31:0] outPC;
    logic        fetch_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instruction    (instruction),
        .outPC          (outPC),
        .fetch_valid    (fetch_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_pc;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] req_log[$];
    pend_t       pend_q[$];
    logic [31:0] model_pc;
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic        prev_stalled;
    logic [31:0] prev_head_pc;
    vec_t        tbl[10];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic logic eff_redirect();
`ifdef FETCH_MISALIGN_CHECK_EN
        return redirect_valid && (redirect_pc[1:0] == 2'b00);
`else
        return redirect_valid;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    // Memory drive for the current cycle, then monitor and scoreboard at the falling edge.
    task automatic cyc_begin();
        logic        xfer;
        logic        redir;
        logic [31:0] e;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        @(negedge clk);
        redir = eff_redirect();
        xfer  = imem_req_valid && imem_req_ready;
        if (prev_hold && imem_req_valid)
            check("req_addr_hold", imem_req_addr, prev_addr);
        if (prev_stalled) begin
            check("stall_head_valid", {31'b0, fetch_valid}, 32'h1);
            check("stall_head_pc", outPC, prev_head_pc);
        end
        if (redir)
            check("no_req_on_redirect", {31'b0, imem_req_valid}, 32'h0);
        if (xfer) begin
            check("req_addr", imem_req_addr, model_pc);
            req_log.push_back(imem_req_addr);
            pend_q.push_back('{imem_req_addr, cyc + lat});
            exp_q.push_back(imem_req_addr);
            model_pc = model_pc + 32'd4;
        end
        if (fetch_valid && !stall && !redir) begin
            check("fetch_expected", {31'b0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("fetch_pc", outPC, e);
                check("fetch_instr", instruction, instr_of(e));
                got_q.push_back(outPC);
            end
        end
        if (redir) begin
            exp_q.delete();
            model_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        prev_hold    = imem_req_valid && !imem_req_ready;
        prev_addr    = imem_req_addr;
        prev_stalled = fetch_valid && stall && !redir;
        prev_head_pc = outPC;
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        cyc_begin();
        cyc_end();
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        pend_q.delete();
        exp_q.delete();
        got_q.delete();
        req_log.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_outpc", outPC, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);
`endif
        @(posedge clk);
        #1;
        reset           = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        model_pc        = RESET_PC;
        cyc             = 0;
        lat             = 1;
        prev_hold       = 1'b0;
        prev_stalled    = 1'b0;
    endtask

    // Stop issuing and let every outstanding response arrive and be consumed.
    task automatic drain();
        int n = 0;
        imem_req_ready = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 60) begin
            cycle();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'h0);
        check("drain_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        check("drain_outpc", outPC, 32'h0);
        check("drain_instruction", instruction, 32'h0);
        imem_req_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        stall = 1'b0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;

        //               stall redir rpc           rv    addr          fv    outPC
        tbl[0] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0000};
        tbl[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
        tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 32'h200,      1'b0, 32'h0,         1'b1, 32'h0000_0008};
        tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0200, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0204, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0200};
        tbl[9] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0208, 1'b1, 32'h0000_0204};

        // Reset release, sequential fetch, then redirect colliding with a response and a pop.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            cyc_begin();
            check($sformatf("tbl%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
            if (tbl[i].e_rv)
                check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_fetch_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].e_fv});
            check($sformatf("tbl%0d_outpc", i), outPC, tbl[i].e_pc);
            check($sformatf("tbl%0d_instr", i), instruction, tbl[i].e_fv ? instr_of(tbl[i].e_pc) : 32'h0);
            cyc_end();
        end
        redirect_valid = 1'b0;
        drain();

        // Stall held five cycles: queue fills to DEPTH, issue stops, nothing lost afterwards.
        do_reset();
        stall = 1'b1;
        repeat (5) cycle();
        check("stall_req_count", 32'(req_log.size()), 32'(DEPTH));
        check("stall_head_final", outPC, 32'h0);
        stall = 1'b0;
        repeat (8) cycle();
        drain();
        check("stall_got_count", {31'b0, got_q.size() >= 2}, 32'h1);
        if (got_q.size() >= 2) begin
            check("stall_got0", got_q[0], 32'h0);
            check("stall_got1", got_q[1], 32'h4);
        end

        // Redirect with two requests still in flight: both responses must be dropped.
        do_reset();
        lat = 3;
        repeat (2) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        repeat (10) cycle();
        drain();
        check("rd2_got_count", {31'b0, got_q.size() >= 2}, 32'h1);
        if (got_q.size() >= 2) begin
            check("rd2_got0", got_q[0], 32'h100);
            check("rd2_got1", got_q[1], 32'h104);
        end

        // PC wrap at the top of the address space.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        repeat (4) cycle();
        check("wrap_req_count", {31'b0, req_log.size() >= 2}, 32'h1);
        if (req_log.size() >= 2) begin
            check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
            check("wrap_req1", req_log[1], 32'h0000_0000);
        end
        drain();

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect is ignored and flagged for one cycle.
        do_reset();
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        cyc_begin();
        check("mis_err_c0", {31'b0, misalign_err}, 32'h0);
        cyc_end();
        redirect_valid = 1'b0;
        cyc_begin();
        check("mis_err_c1", {31'b0, misalign_err}, 32'h1);
        cyc_end();
        cyc_begin();
        check("mis_err_c2", {31'b0, misalign_err}, 32'h0);
        cyc_end();
        repeat (4) cycle();
        drain();
        for (int i = 0; i < req_log.size(); i++)
            check($sformatf("mis_seq%0d", i), req_log[i], 32'(i * 4));
`else
        // Low target bits are cleared.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h106;
        cycle();
        redirect_valid = 1'b0;
        repeat (4) cycle();
        check("mask_req_count", {31'b0, req_log.size() >= 1}, 32'h1);
        if (req_log.size() >= 1)
            check("mask_req0", req_log[0], 32'h104);
        drain();
`endif

        // Random stall, back-pressure, latency and redirects.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 4) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom();
            lat            = $urandom_range(1, 3);
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the fetch queue depth in entries; legal values are 2 and 4.
REQ-003 SHALL use a single clock and an asynchronous active-high reset, with the ports named `clk` and `reset` and no other clock or reset.
REQ-004 SHALL have port `clk`, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 SHALL have port `reset`, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port `redirect_valid`, input, 1 bit: branch/jump redirect request.
REQ-007 SHALL have port `redirect_pc`, input, 32 bits: the redirect target address.
REQ-008 SHALL have port `stall`, input, 1 bit: the downstream IF/ID register cannot accept an instruction.
REQ-009 SHALL have port `imem_req_valid`, output, 1 bit: instruction memory request valid.
REQ-010 SHALL have port `imem_req_addr`, output, 32 bits: the request byte address.
REQ-011 SHALL have port `imem_req_ready`, input, 1 bit: memory accepts the request.
REQ-012 SHALL have port `imem_resp_valid`, input, 1 bit: response valid; responses return in order and are never back-pressured.
REQ-013 SHALL have port `imem_resp_data`, input, 32 bits: the instruction word.
REQ-014 SHALL have port `instruction`, output, 32 bits: the queue-head instruction, which feeds IF/ID `instruction`.
REQ-015 SHALL have port `outPC`, output, 32 bits: the queue-head instruction address, which feeds IF/ID `outPC`; IF/ID adds 4 itself.
REQ-016 SHALL have port `fetch_valid`, output, 1 bit: the head entry is valid.
REQ-017 SHALL have port `misalign_err`, output, 1 bit, present only under the macro in REQ-034.

Function
REQ-018 SHALL hold a fetch PC; a request transfers when imem_req_valid and imem_req_ready are both 1 in the same cycle; on a transfer, imem_req_addr equals the PC and the PC becomes PC+4, wrapping modulo 2^32.
REQ-019 SHALL assert imem_req_valid only when queue occupancy plus outstanding requests is less than DEPTH and redirect_valid is 0.
REQ-020 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-021 SHALL track up to DEPTH outstanding requests with a counter: +1 per transfer, -1 per response, no change when both occur in the same cycle.
REQ-022 SHALL push {imem_resp_data, request address} into the queue on each non-dropped response; the entry is visible on instruction/outPC with fetch_valid=1 one cycle after the response.
REQ-023 SHALL pop the head when fetch_valid=1 and stall=0; a push and a pop in the same cycle are allowed even when the queue is full.
REQ-024 SHALL hold instruction/outPC stable while stall=1, and drive both to 0 when the queue is empty.
REQ-025 On redirect_valid=1, SHALL set PC to redirect_pc, empty the queue, set fetch_valid to 0 in the next cycle, and issue no request in the redirect cycle.
REQ-026 On redirect, SHALL load a drop counter with the in-flight count; each later response decrements the counter and is discarded until it reaches 0; a response arriving in the redirect cycle itself is discarded.
REQ-027 SHALL give redirect priority over stall, push, and pop in the same cycle.
REQ-028 SHALL stop issuing when DEPTH is reached and SHALL never lose or duplicate an instruction.

Reset
REQ-029 While reset=1, SHALL hold PC=RESET_PC, queue empty, outstanding=0, drop counter=0, and imem_req_valid=0.
REQ-030 While reset=1, SHALL hold fetch_valid=0, instruction=0, outPC=0, and imem_req_addr=RESET_PC.
REQ-031 SHALL assert imem_req_valid in the first cycle after reset deasserts.
REQ-032 SHALL discard any memory response received while reset=1.
REQ-033 Reset asserted mid-transfer SHALL abandon all in-flight state.

Configuration
REQ-034 With macro FETCH_MISALIGN_CHECK_EN defined, a redirect to a target where redirect_pc[1:0]!=0 SHALL be ignored (no PC change, no queue flush).
REQ-035 With FETCH_MISALIGN_CHECK_EN defined, misalign_err SHALL pulse to 1 for exactly one cycle on such a redirect; it resets to 0.
REQ-036 With FETCH_MISALIGN_CHECK_EN undefined, the misalign_err port SHALL be absent and redirect_pc SHALL be used with bits [1:0] forced to 0.

Verification
REQ-037 The bench SHALL cover: reset release with memory at 1-cycle latency and ready tied high -> addresses 0x0,0x4,0x8 requested; outPC sequence 0x0,0x4,0x8 with matching data.
REQ-038 The bench SHALL cover: stall=1 held 5 cycles with DEPTH=2 -> at most 2 entries buffered, no further requests, head stable, no loss once stall=0.
REQ-039 The bench SHALL cover: redirect to 0x100 with 2 requests in flight -> both responses dropped, next outPC=0x100, then 0x104.
REQ-040 The bench SHALL cover: redirect in the same cycle as a response and a pop -> response discarded, queue empty next cycle, request 0x200 issued the cycle after.
REQ-041 The bench SHALL cover: PC=0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-042 The bench SHALL cover, with FETCH_MISALIGN_CHECK_EN defined: redirect to 0x102 -> misalign_err pulses 1 cycle, fetch continues sequentially.
